// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage between EX/MEM and MEM/WB with req/ack bus
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PIP_write_mem_i,
  input  logic        PIP_read_mem_i,
  input  logic [31:0] PIP_alu_result_i,
  input  logic [31:0] PIP_second_operand_i,
  input  logic [1:0]  PIP_mem_size_i,
  input  logic        PIP_mem_unsigned_i,
  input  logic        PIP_use_mem_i,
  input  logic        PIP_write_reg_i,
  input  logic [4:0]  PIP_rd_i,
  input  logic        PIP_TRAP_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic [31:0] EX_MEM_operand_o,
  output logic [31:0] PIP_wb_data_o,
  output logic        PIP_write_reg_o,
  output logic [4:0]  PIP_rd_o,
  output logic        PIP_TRAP_o,
  output logic [31:0] MEM_WB_operand_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic             we_q, uns_q;
  logic [1:0]       size_q;
  logic             mem_op, fault, access, busy, timeout, trap_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c, lane, load_data;
  logic [1:0]       off, sz;
  logic             uns;

  assign mem_op  = PIP_read_mem_i | PIP_write_mem_i;
  // misalignment, reserved size and read+write are only meaningful for memory ops
  assign fault   = mem_op & ((PIP_mem_size_i == 2'b11) |
                             (PIP_mem_size_i == 2'b01 & PIP_alu_result_i[0]) |
                             (PIP_mem_size_i == 2'b10 & |PIP_alu_result_i[1:0]) |
                             (PIP_read_mem_i & PIP_write_mem_i));
  assign access  = mem_op & ~PIP_TRAP_i & ~fault;
  assign busy    = state == BUSY;
  assign timeout = busy & ~dmem_ack_i & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // ack or timeout cycle releases the stall so the pipeline advances on the next edge
  assign stall_o    = reset_n & (busy ? ~dmem_ack_i & ~timeout : access & ~dmem_ack_i);
  assign dmem_req_o = reset_n & (busy | access);

  assign be_c    = PIP_mem_size_i == 2'b00 ? 4'b0001 << PIP_alu_result_i[1:0] :
                   PIP_mem_size_i == 2'b01 ? 4'b0011 << PIP_alu_result_i[1:0] : 4'b1111;
  assign wdata_c = PIP_mem_size_i == 2'b00 ? {4{PIP_second_operand_i[7:0]}} :
                   PIP_mem_size_i == 2'b01 ? {2{PIP_second_operand_i[15:0]}} : PIP_second_operand_i;

  assign dmem_we_o    = busy ? we_q : PIP_write_mem_i;
  assign dmem_addr_o  = busy ? {addr_q[31:2], 2'b00} : {PIP_alu_result_i[31:2], 2'b00};
  assign dmem_be_o    = busy ? be_q : be_c;
  assign dmem_wdata_o = busy ? wdata_q : wdata_c;

  assign off  = busy ? addr_q[1:0] : PIP_alu_result_i[1:0];
  assign sz   = busy ? size_q : PIP_mem_size_i;
  assign uns  = busy ? uns_q : PIP_mem_unsigned_i;
  assign lane = dmem_rdata_i >> {off, 3'b000};
  assign load_data = sz == 2'b00 ? (uns ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]}) :
                     sz == 2'b01 ? (uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]}) : lane;

  assign trap_c           = PIP_TRAP_i | fault | timeout;
  assign EX_MEM_operand_o = PIP_alu_result_i;
  assign MEM_WB_operand_o = PIP_wb_data_o;

  // FSM and request latches: capture the access when it cannot finish in one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else if (!busy) begin
      if (access && !dmem_ack_i) begin
        state   <= BUSY;
        cnt     <= '0;
        addr_q  <= PIP_alu_result_i;
        wdata_q <= wdata_c;
        be_q    <= be_c;
        we_q    <= PIP_write_mem_i;
        size_q  <= PIP_mem_size_i;
        uns_q   <= PIP_mem_unsigned_i;
      end
    end else if (dmem_ack_i || timeout) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // MEM/WB register: bubble while stalled, otherwise retire the instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      PIP_wb_data_o   <= '0;
      PIP_write_reg_o <= 1'b0;
      PIP_rd_o        <= '0;
      PIP_TRAP_o      <= 1'b0;
    end else if (stall_o) begin
      PIP_write_reg_o <= 1'b0;
      PIP_TRAP_o      <= 1'b0;
    end else begin
      PIP_wb_data_o   <= PIP_use_mem_i ? load_data : PIP_alu_result_i;
      PIP_write_reg_o <= PIP_write_reg_i & ~trap_c;
      PIP_rd_o        <= PIP_rd_i;
      PIP_TRAP_o      <= trap_c;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        PIP_write_mem_i, PIP_read_mem_i, PIP_mem_unsigned_i, PIP_use_mem_i;
  logic        PIP_write_reg_i, PIP_TRAP_i, dmem_ack_i;
  logic [31:0] PIP_alu_result_i, PIP_second_operand_i, dmem_rdata_i;
  logic [1:0]  PIP_mem_size_i;
  logic [4:0]  PIP_rd_i;
  logic        dmem_req_o, dmem_we_o, stall_o, PIP_write_reg_o, PIP_TRAP_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, EX_MEM_operand_o, PIP_wb_data_o, MEM_WB_operand_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  PIP_rd_o;

  typedef struct {logic [31:0] d; logic w; logic [4:0] r; logic t;} exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int stalls;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n),
    .PIP_write_mem_i(PIP_write_mem_i), .PIP_read_mem_i(PIP_read_mem_i),
    .PIP_alu_result_i(PIP_alu_result_i), .PIP_second_operand_i(PIP_second_operand_i),
    .PIP_mem_size_i(PIP_mem_size_i), .PIP_mem_unsigned_i(PIP_mem_unsigned_i),
    .PIP_use_mem_i(PIP_use_mem_i), .PIP_write_reg_i(PIP_write_reg_i),
    .PIP_rd_i(PIP_rd_i), .PIP_TRAP_i(PIP_TRAP_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
    .dmem_ack_i(dmem_ack_i), .stall_o(stall_o), .EX_MEM_operand_o(EX_MEM_operand_o),
    .PIP_wb_data_o(PIP_wb_data_o), .PIP_write_reg_o(PIP_write_reg_o),
    .PIP_rd_o(PIP_rd_o), .PIP_TRAP_o(PIP_TRAP_o), .MEM_WB_operand_o(MEM_WB_operand_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                        input logic use_mem, input logic wreg, input logic [4:0] rdst);
    PIP_read_mem_i = rd; PIP_write_mem_i = wr; PIP_alu_result_i = addr;
    PIP_second_operand_i = wd; PIP_mem_size_i = sz; PIP_mem_unsigned_i = uns;
    PIP_use_mem_i = use_mem; PIP_write_reg_i = wreg; PIP_rd_i = rdst; PIP_TRAP_i = 1'b0;
  endtask

  task automatic nop();
    set_op(0, 0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 5'd0);
  endtask

  task automatic push(input logic [31:0] d, input logic w, input logic [4:0] r, input logic t);
    exp_t e;
    e.d = d; e.w = w; e.r = r; e.t = t;
    q.push_back(e);
  endtask

  // Entered just after a posedge with the op driven; ack is raised in cycle ack_at (-1: never).
  task automatic run(input int ack_at, input logic [31:0] rdata, output int n);
    logic s;
    bit done = 0;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      dmem_ack_i = (i == ack_at);
      dmem_rdata_i = rdata;
      #3;
      s = stall_o;
      if (s) n++;
      @(posedge clk); #1;
      if (!s) done = 1;
    end
    if (!done) begin
      checks++;
      $display("FAIL run_bound: stall_o still high after 40 cycles, expected release");
    end
    dmem_ack_i = 1'b0;
    nop();
  endtask

  // Monitor: every retired instruction (write or trap) is compared with the scoreboard head
  always @(negedge clk) begin
    if (reset_n && (PIP_write_reg_o || PIP_TRAP_o)) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_retire: got wb=%h rd=%0d trap=%b, expected no retire",
                 PIP_wb_data_o, PIP_rd_o, PIP_TRAP_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_data", PIP_wb_data_o, e.d);
        chk("write_reg", {31'b0, PIP_write_reg_o}, {31'b0, e.w});
        chk("rd", {27'b0, PIP_rd_o}, {27'b0, e.r});
        chk("trap", {31'b0, PIP_TRAP_o}, {31'b0, e.t});
        chk("mem_wb_fwd", MEM_WB_operand_o, e.d);
      end
    end
  end

  initial begin
    nop();
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, dmem_req_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_wb", PIP_wb_data_o, 32'h0);
    chk("rst_rd", {27'b0, PIP_rd_o}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait word load
    set_op(1, 0, 32'h100, 32'h0, 2'b10, 0, 1, 1, 5'd5);
    push(32'hDEADBEEF, 1, 5'd5, 0);
    #1;
    chk("ld_req", {31'b0, dmem_req_o}, 32'h1);
    chk("ld_addr", dmem_addr_o, 32'h100);
    chk("ld_be", {28'b0, dmem_be_o}, 32'hF);
    chk("ex_mem_fwd", EX_MEM_operand_o, 32'h100);
    run(0, 32'hDEADBEEF, stalls);
    chk("ld_stalls", stalls, 0);
    repeat (2) @(posedge clk); #1;

    // signed byte load, ack in the fourth request cycle
    set_op(1, 0, 32'h103, 32'h0, 2'b00, 0, 1, 1, 5'd6);
    push(32'hFFFFFF80, 1, 5'd6, 0);
    #1;
    chk("lb_addr", dmem_addr_o, 32'h100);
    chk("lb_be", {28'b0, dmem_be_o}, 32'h8);
    run(3, 32'h80FF0000, stalls);
    chk("lb_stalls", stalls, 3);
    repeat (2) @(posedge clk); #1;

    // unsigned byte load
    set_op(1, 0, 32'h103, 32'h0, 2'b00, 1, 1, 1, 5'd8);
    push(32'h00000080, 1, 5'd8, 0);
    run(3, 32'h80FF0000, stalls);
    chk("lbu_stalls", stalls, 3);
    repeat (2) @(posedge clk); #1;

    // half store with (illegal) register write: writes back the address
    set_op(0, 1, 32'h202, 32'h1234ABCD, 2'b01, 0, 0, 1, 5'd7);
    push(32'h202, 1, 5'd7, 0);
    #1;
    chk("sh_addr", dmem_addr_o, 32'h200);
    chk("sh_be", {28'b0, dmem_be_o}, 32'hC);
    chk("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
    chk("sh_we", {31'b0, dmem_we_o}, 32'h1);
    run(1, 32'h0, stalls);
    chk("sh_stalls", stalls, 1);
    repeat (2) @(posedge clk); #1;

    // misaligned word load traps without a bus request
    set_op(1, 0, 32'h101, 32'h0, 2'b10, 0, 1, 1, 5'd10);
    push(32'h0, 0, 5'd10, 1);
    #1;
    chk("mis_req", {31'b0, dmem_req_o}, 32'h0);
    run(-1, 32'h0, stalls);
    chk("mis_stalls", stalls, 0);
    repeat (2) @(posedge clk); #1;

    // bus timeout then a late ack that must be ignored
    set_op(1, 0, 32'h300, 32'h0, 2'b10, 0, 1, 1, 5'd9);
    push(32'h0, 0, 5'd9, 1);
    run(-1, 32'h0, stalls);
    chk("to_stalls", stalls, 16);
    dmem_ack_i = 1'b1;
    #1;
    chk("late_ack_stall", {31'b0, stall_o}, 32'h0);
    chk("late_ack_req", {31'b0, dmem_req_o}, 32'h0);
    repeat (2) @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    repeat (2) @(posedge clk); #1;

    // asynchronous reset while BUSY
    set_op(1, 0, 32'h400, 32'h0, 2'b10, 0, 1, 1, 5'd3);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_stall", {31'b0, stall_o}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, dmem_req_o}, 32'h0);
    chk("arst_stall", {31'b0, stall_o}, 32'h0);
    chk("arst_wb", PIP_wb_data_o, 32'h0);
    chk("arst_wr", {31'b0, PIP_write_reg_o}, 32'h0);
    chk("arst_rd", {27'b0, PIP_rd_o}, 32'h0);
    chk("arst_trap", {31'b0, PIP_TRAP_o}, 32'h0);
    nop();
    dmem_ack_i = 1'b1;
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // load after reset completes normally
    set_op(1, 0, 32'h104, 32'h0, 2'b10, 0, 1, 1, 5'd4);
    push(32'h11223344, 1, 5'd4, 0);
    run(0, 32'h11223344, stalls);
    chk("post_rst_stalls", stalls, 0);
    repeat (3) @(posedge clk); #1;

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the EX/MEM pipeline registers and performs data-memory loads and stores over a req/ack bus.
- Aligns and extends load data, produces the MEM/WB pipeline registers, and stalls the front of the pipeline while a bus transaction is outstanding.
- Also drives the forwarding operands back to execute.

Parameters:
- TIMEOUT_CYCLES, 16: cycles waited in BUSY for dmem_ack_i before the access is aborted with a bus-error trap.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- PIP_write_mem_i  in  1  store request, from EX/MEM.
- PIP_read_mem_i  in  1  load request, from EX/MEM.
- PIP_alu_result_i  in  32  ALU result; byte address for loads and stores.
- PIP_second_operand_i  in  32  store data, rs2 after forwarding.
- PIP_mem_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- PIP_mem_unsigned_i  in  1  zero-extend loads when 1, sign-extend when 0.
- PIP_use_mem_i  in  1  write-back value comes from memory (load).
- PIP_write_reg_i  in  1  register-file write enable.
- PIP_rd_i  in  5  destination register.
- PIP_TRAP_i  in  1  trap flag from upstream.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  bus write enable.
- dmem_addr_o  out  32  word-aligned address, i.e. {addr[31:2],2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  store data, lane-replicated.
- dmem_rdata_i  in  32  load data, valid when dmem_ack_i is high.
- dmem_ack_i  in  1  transaction complete.
- stall_o  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- EX_MEM_operand_o  out  32  equals PIP_alu_result_i (combinational), forwarded to execute.
- PIP_wb_data_o  out  32  MEM/WB write-back data.
- PIP_write_reg_o  out  1  MEM/WB register-file write enable.
- PIP_rd_o  out  5  MEM/WB destination register.
- PIP_TRAP_o  out  1  MEM/WB trap flag.
- MEM_WB_operand_o  out  32  equals PIP_wb_data_o, forwarded to execute.

Behaviour:
- Reset:
  - reset_n low asynchronously forces state IDLE and zeroes the timeout counter, the address/data/byte-enable latches, PIP_wb_data_o, PIP_write_reg_o, PIP_rd_o and PIP_TRAP_o.
  - dmem_req_o is 0 during reset; release is synchronous to clk.
  - Reset mid-transaction drops dmem_req_o immediately and discards any later ack.
- access = (PIP_read_mem_i | PIP_write_mem_i) & ~PIP_TRAP_i & ~fault.
- fault (combinational) is set by any of:
  - size 11;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - read and write both asserted.
  - A fault issues no bus request.
- Byte enables:
  - byte: 0001<<addr[1:0];
  - half: 0011<<addr[1:0];
  - word: 1111.
- Store data:
  - byte: {4{rs2[7:0]}};
  - half: {2{rs2[15:0]}};
  - word: rs2.
- Load data:
  - lane selected by addr[1:0];
  - 8- or 16-bit result sign- or zero-extended per PIP_mem_unsigned_i.
- FSM, IDLE state:
  - If access, assert dmem_req_o combinationally with the current address, byte enables and data.
  - If dmem_ack_i is also high in the same cycle (zero-wait), the access completes; stall_o=0.
  - Otherwise latch address, byte enables, write data, we, size and unsigned; go to BUSY; stall_o=1.
- FSM, BUSY state:
  - dmem_req_o=1, driven from the latches; stall_o=1; counter increments each cycle.
  - On dmem_ack_i: completion; go to IDLE. stall_o is 0 in the ack cycle so the pipeline advances on the next edge.
  - When the counter reaches TIMEOUT_CYCLES-1 without ack: go to IDLE; the access completes as a bus error; the counter clears.
- MEM/WB update, every posedge when not in reset:
  - While stalled: write a bubble, i.e. PIP_write_reg_o=0 and PIP_TRAP_o=0.
  - On completion or a non-memory op:
    - PIP_wb_data_o = PIP_use_mem_i ? load_data : PIP_alu_result_i;
    - PIP_write_reg_o and PIP_rd_o pass through;
    - PIP_TRAP_o = PIP_TRAP_i | fault | bus_error.
  - When PIP_TRAP_o is set, PIP_write_reg_o is forced to 0.
- Inputs are held stable by upstream while stall_o=1. The latches make bus signalling independent of input changes in BUSY regardless.
- Stores with PIP_write_reg_i=1 (illegal decode) still write PIP_alu_result_i.
- The execute stage must gate its pipeline-register update with stall_o.

Test Plan:
- Word load, addr 0x100, ack in the same cycle, rdata 0xDEADBEEF → no stall; next cycle PIP_wb_data_o=0xDEADBEEF, PIP_write_reg_o=1, rd passed through.
- Signed byte load from addr 0x103, rdata 0x80FF_0000, ack after 3 cycles → stall_o high for 3 cycles with bubbles in MEM/WB; PIP_wb_data_o=0xFFFFFF80. The unsigned variant gives 0x00000080.
- Half store of rs2=0x1234ABCD at addr 0x202 → dmem_addr_o=0x200, dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1.
- Misaligned word load at 0x101 → dmem_req_o never asserted, no stall; PIP_TRAP_o=1, PIP_write_reg_o=0.
- No ack for TIMEOUT_CYCLES=16 → stall_o high for 16 cycles, then PIP_TRAP_o=1 and FSM back in IDLE. A late ack is ignored.
- reset_n pulsed low in BUSY at cycle 2 → dmem_req_o and stall_o drop without a clock edge; all MEM/WB outputs are 0; the next load after reset completes normally.
